// File: rtl/fpga_rst_pkg.sv
// Shared types and helpers for the FPGA board reset sequencer.
package fpga_rst_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK  = 2'd0,
    STRETCH    = 2'd1,
    REL_PERIPH = 2'd2,
    RUN        = 2'd3
  } rst_state_e;

  typedef enum logic [1:0] {
    CAUSE_POR    = 2'b00,
    CAUSE_BUTTON = 2'b01,
    CAUSE_LOCK   = 2'b10,
    CAUSE_SOFT   = 2'b11
  } rst_cause_e;

  // Counter width wide enough for the largest of three cycle counts, plus one bit.
  function automatic int unsigned cnt_width(input int unsigned a,
                                            input int unsigned b,
                                            input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/fpga_rst_sequencer_if.sv
// Board-side reset inputs and SoC-side reset outputs of the sequencer.
interface fpga_rst_sequencer_if;
  logic       pad_reset_i;
  logic       clk_locked_i;
  logic       soft_reset_req_i;
  logic       periph_rst_no;
  logic       jtag_trst_no;
  logic       soc_rst_no;
  logic       rst_busy_o;
  logic [1:0] rst_cause_o;

  modport master (
    output pad_reset_i, clk_locked_i, soft_reset_req_i,
    input  periph_rst_no, jtag_trst_no, soc_rst_no, rst_busy_o, rst_cause_o
  );

  modport slave (
    input  pad_reset_i, clk_locked_i, soft_reset_req_i,
    output periph_rst_no, jtag_trst_no, soc_rst_no, rst_busy_o, rst_cause_o
  );
endinterface

// File: rtl/fpga_rst_debounce.sv
// Synchronizer plus stable-level filter for an asynchronous, bouncy input.
module fpga_rst_debounce
  import fpga_rst_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 20000,
  parameter logic        RST_LEVEL       = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  localparam int unsigned CNT_W = cnt_width(DEBOUNCE_CYCLES, 1, 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   level_c;

  assign level_c = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= {SYNC_STAGES{RST_LEVEL}};
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], din};
  end

  // Count only while the synchronized level differs from the filtered one;
  // any return to the filtered level restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      dout  <= RST_LEVEL;
    end else if (level_c == dout) begin
      cnt_q <= '0;
    end else if (cnt_q >= CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      cnt_q <= '0;
      dout  <= level_c;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/fpga_rst_sequencer.sv
// Board reset controller: waits for lock and button release, stretches reset,
// then releases peripheral/JTAG before SoC and records the last reset cause.
module fpga_rst_sequencer
  import fpga_rst_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 20000,
  parameter int unsigned STRETCH_CYCLES  = 1024,
  parameter int unsigned SOC_DELAY       = 16
) (
  input  logic                 ref_clk_i,
  input  logic                 rst_ni,
  fpga_rst_sequencer_if.slave  bus
);

  localparam int unsigned CNT_W   = cnt_width(STRETCH_CYCLES, SOC_DELAY, DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  rst_state_e             state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [SYNC_STAGES-1:0] lock_sync_q;
  logic                   lock_s;
  logic                   btn_db;
  logic                   periph_q, jtag_q, soc_q, busy_q;
  rst_cause_e             cause_q;
  logic                   trigger_c;
  rst_cause_e             trig_cause_c;
  logic [CNT_W-1:0]       cnt_inc_c;

  fpga_rst_debounce #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .RST_LEVEL       (1'b1)
  ) u_btn_debounce (
    .clk   (ref_clk_i),
    .rst_n (rst_ni),
    .din   (bus.pad_reset_i),
    .dout  (btn_db)
  );

  always_ff @(posedge ref_clk_i or negedge rst_ni) begin
    if (!rst_ni) lock_sync_q <= '0;
    else         lock_sync_q <= {lock_sync_q[SYNC_STAGES-2:0], bus.clk_locked_i};
  end

  assign lock_s = lock_sync_q[SYNC_STAGES-1];

  // Triggers only apply once sequencing has started; priority lock > button > soft.
  assign trigger_c = (state_q != WAIT_LOCK) &&
                     (!lock_s || btn_db || (bus.soft_reset_req_i && state_q == RUN));
  assign trig_cause_c = !lock_s ? CAUSE_LOCK :
                        btn_db  ? CAUSE_BUTTON : CAUSE_SOFT;
  assign cnt_inc_c = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

  always_ff @(posedge ref_clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= WAIT_LOCK;
      cnt_q    <= '0;
      periph_q <= 1'b0;
      jtag_q   <= 1'b0;
      soc_q    <= 1'b0;
      busy_q   <= 1'b1;
      cause_q  <= CAUSE_POR;
    end else if (trigger_c) begin
      state_q  <= WAIT_LOCK;
      cnt_q    <= '0;
      periph_q <= 1'b0;
      jtag_q   <= 1'b0;
      soc_q    <= 1'b0;
      busy_q   <= 1'b1;
      cause_q  <= trig_cause_c;
    end else begin
      case (state_q)
        WAIT_LOCK: begin
          if (lock_s && !btn_db) begin
            state_q <= STRETCH;
            cnt_q   <= '0;
          end
        end
        STRETCH: begin
          if (cnt_q == CNT_W'(STRETCH_CYCLES - 1)) begin
            state_q  <= REL_PERIPH;
            cnt_q    <= '0;
            periph_q <= 1'b1;
            jtag_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_inc_c;
          end
        end
        REL_PERIPH: begin
          if (cnt_q == CNT_W'(SOC_DELAY - 1)) begin
            state_q <= RUN;
            soc_q   <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_inc_c;
          end
        end
        RUN: begin
          state_q <= RUN;
        end
        default: state_q <= WAIT_LOCK;
      endcase
    end
  end

  assign bus.periph_rst_no = periph_q;
  assign bus.jtag_trst_no  = jtag_q;
  assign bus.soc_rst_no    = soc_q;
  assign bus.rst_busy_o    = busy_q;
  assign bus.rst_cause_o   = cause_q;

endmodule

// File: tb/tb_fpga_rst_sequencer.sv
// Directed bench for fpga_rst_sequencer with short debounce/stretch settings.
module tb_fpga_rst_sequencer;
  import fpga_rst_pkg::*;

  logic ref_clk_i = 1'b0;
  logic rst_ni;
  int   n_assert = 0;
  int   n_fail   = 0;

  always #5 ref_clk_i = ~ref_clk_i;

  fpga_rst_sequencer_if bus();

  fpga_rst_sequencer #(
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (8),
    .STRETCH_CYCLES  (16),
    .SOC_DELAY       (4)
  ) dut (
    .ref_clk_i (ref_clk_i),
    .rst_ni    (rst_ni),
    .bus       (bus.slave)
  );

  // {periph, jtag, soc, busy, cause}
  logic [5:0] outs;
  assign outs = {bus.periph_rst_no, bus.jtag_trst_no, bus.soc_rst_no,
                 bus.rst_busy_o, bus.rst_cause_o};

  function automatic logic [5:0] v_rst(input logic [1:0] c);
    return {4'b0001, c};
  endfunction
  function automatic logic [5:0] v_per(input logic [1:0] c);
    return {4'b1101, c};
  endfunction
  function automatic logic [5:0] v_run(input logic [1:0] c);
    return {4'b1110, c};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge ref_clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [5:0] obs, input logic [5:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Reset held for 'hold' edges, then periph release, then SoC release 4 edges later.
  task automatic tail_seq(input string tag, input logic [1:0] c, input int hold);
    tick(hold);
    check({tag, "_hold"}, outs, v_rst(c));
    tick(1);
    check({tag, "_periph"}, outs, v_per(c));
    tick(3);
    check({tag, "_soc_wait"}, outs, v_per(c));
    tick(1);
    check({tag, "_run"}, outs, v_run(c));
  endtask

  initial begin
    rst_ni               = 1'b0;
    bus.pad_reset_i      = 1'b0;
    bus.clk_locked_i     = 1'b1;
    bus.soft_reset_req_i = 1'b0;

    // Power-on: 2 sync + 8 debounce + 1 decision + 16 stretch = edge 27
    tick(3);
    check("por_reset", outs, v_rst(2'b00));
    @(negedge ref_clk_i);
    rst_ni = 1'b1;
    tail_seq("por", 2'b00, 26);

    // Button bounce shorter than the debounce window is ignored
    tick(3);
    for (int i = 0; i < 10; i++) begin
      bus.pad_reset_i = (i % 2 == 0);
      tick(3);
      check("bounce", outs, v_run(2'b00));
    end
    tick(4);
    check("bounce_settled", outs, v_run(2'b00));

    // Button held 10 cycles: reset at edge 11, re-release 27 edges after release
    bus.pad_reset_i = 1'b1;
    tick(10);
    check("btn_before", outs, v_run(2'b00));
    bus.pad_reset_i = 1'b0;
    tick(1);
    check("btn_assert", outs, v_rst(2'b01));
    tail_seq("btn", 2'b01, 25);

    // One-cycle lock loss: reset 3 edges later, stretch restarts immediately after
    tick(2);
    bus.clk_locked_i = 1'b0;
    tick(1);
    bus.clk_locked_i = 1'b1;
    check("lock_e1", outs, v_run(2'b01));
    tick(1);
    check("lock_e2", outs, v_run(2'b01));
    tick(1);
    check("lock_assert", outs, v_rst(2'b10));
    tail_seq("lock", 2'b10, 16);

    // Soft reset in RUN; a second pulse during STRETCH must not restart it
    tick(2);
    bus.soft_reset_req_i = 1'b1;
    tick(1);
    bus.soft_reset_req_i = 1'b0;
    check("soft_assert", outs, v_rst(2'b11));
    tick(4);
    bus.soft_reset_req_i = 1'b1;
    tick(1);
    bus.soft_reset_req_i = 1'b0;
    check("soft_in_stretch", outs, v_rst(2'b11));
    tail_seq("soft", 2'b11, 11);

    // Lock loss and debounced press reach the FSM together: lock wins
    tick(2);
    bus.pad_reset_i = 1'b1;
    tick(8);
    bus.clk_locked_i = 1'b0;
    check("simul_pre", outs, v_run(2'b11));
    tick(2);
    check("simul_e10", outs, v_run(2'b11));
    tick(1);
    check("simul_cause", outs, v_rst(2'b10));
    bus.pad_reset_i  = 1'b0;
    bus.clk_locked_i = 1'b1;
    tail_seq("simul", 2'b10, 26);

    // Async rst_ni during REL_PERIPH
    tick(2);
    bus.soft_reset_req_i = 1'b1;
    tick(1);
    bus.soft_reset_req_i = 1'b0;
    check("por2_soft", outs, v_rst(2'b11));
    tick(18);
    check("por2_relper", outs, v_per(2'b11));
    rst_ni = 1'b0;
    #1;
    check("por2_async", outs, v_rst(2'b00));
    tick(2);
    check("por2_held", outs, v_rst(2'b00));
    @(negedge ref_clk_i);
    rst_ni = 1'b1;
    tail_seq("por2", 2'b00, 26);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
